// File: rtl/matrix_result_collector.sv
// matrix_result_collector: buffers one M*P result matrix from the accelerator and
// replays it row-major over a valid/ready port with row/col tags and a last marker.
module matrix_result_collector #(
    parameter int M          = 3,
    parameter int P          = 3,
    parameter int DATA_WIDTH = 8,
    localparam int N  = M * P,
    localparam int DW = 2 * DATA_WIDTH,
    localparam int PW = (N > 1) ? $clog2(N) : 1,
    localparam int RW = (M > 1) ? $clog2(M) : 1,
    localparam int CW = (P > 1) ? $clog2(P) : 1,
    localparam int NW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic [DW-1:0] result_in,
    input  logic          result_valid,
    input  logic          comp_done,
    output logic [DW-1:0] out_data,
    output logic [RW-1:0] out_row,
    output logic [CW-1:0] out_col,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          buffer_full,
    output logic [NW-1:0] collect_count,
    output logic          short_err,
    output logic          overflow_err
);
    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;
    state_t        state_q, state_d;
    logic [DW-1:0] mem_q [N];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          short_q, short_d, ovf_q, ovf_d, we;
    assign out_valid     = (state_q == DRAIN);
    assign buffer_full   = out_valid;
    assign out_data      = out_valid ? mem_q[rd_q] : '0;
    assign out_row       = row_q;
    assign out_col       = col_q;
    assign out_last      = out_valid && (NW'(rd_q) == cnt_q - NW'(1));
    assign collect_count = cnt_q;
    assign short_err     = short_q;
    assign overflow_err  = ovf_q;
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        short_d = short_q;
        ovf_d   = ovf_q;
        we      = 1'b0;
        if (clear) begin
            state_d = IDLE;
            wr_d    = '0;
            rd_d    = '0;
            cnt_d   = '0;
            row_d   = '0;
            col_d   = '0;
            short_d = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (result_valid) begin
                    we      = 1'b1;
                    wr_d    = PW'(1);
                    cnt_d   = NW'(1);
                    state_d = (N == 1) ? DRAIN : COLLECT;
                end
                COLLECT: begin
                    if (result_valid) begin
                        we    = 1'b1;
                        wr_d  = wr_q + PW'(1);
                        cnt_d = cnt_q + NW'(1);
                    end
                    // done is judged after this cycle's write has been counted
                    if (cnt_d == NW'(N)) state_d = DRAIN;
                    else if (comp_done) begin
                        short_d = 1'b1;
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (result_valid) ovf_d = 1'b1;
                    if (out_ready) begin
                        if (out_last) begin
                            state_d = IDLE;
                            wr_d    = '0;
                            rd_d    = '0;
                            cnt_d   = '0;
                            row_d   = '0;
                            col_d   = '0;
                        end else begin
                            rd_d  = rd_q + PW'(1);
                            col_d = (col_q == CW'(P - 1)) ? '0 : col_q + CW'(1);
                            row_d = (col_q == CW'(P - 1)) ? row_q + RW'(1) : row_q;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            short_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            short_q <= short_d;
            ovf_q   <= ovf_d;
        end
    end
    always_ff @(posedge clk) begin
        if (we) mem_q[wr_q] <= result_in;
    end
endmodule

// File: tb/tb_matrix_result_collector.sv
// tb_matrix_result_collector: directed vector table plus hand-written drain/stall,
// short-matrix, overflow, clear and async-reset sequences.
module tb_matrix_result_collector;
    logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
    logic [15:0] result_in = '0;
    logic        result_valid = 1'b0, comp_done = 1'b0, out_ready = 1'b0;
    logic [15:0] out_data;
    logic [1:0]  out_row, out_col;
    logic        out_valid, out_last, buffer_full, short_err, overflow_err;
    logic [3:0]  collect_count;
    int          n_cmp = 0, n_err = 0;
    logic [15:0] ex [9];

    matrix_result_collector #(.M(3), .P(3), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .result_in(result_in),
        .result_valid(result_valid), .comp_done(comp_done), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .buffer_full(buffer_full),
        .collect_count(collect_count), .short_err(short_err), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [15:0] din;
        logic        done;
        logic        rdy;
        logic        ev;
        logic [15:0] ed;
        logic [1:0]  er, ec;
        logic        el;
        logic [3:0]  ecnt;
    } vec_t;
    vec_t tv [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            result_valid = 1'b1;
            result_in    = ex[i];
            tick();
        end
        result_valid = 1'b0;
    endtask

    task automatic drain(input int n, input bit tog);
        int k = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        logic [15:0] pd;
        logic [1:0] pr, pc;
        logic pl;
        while (k < n && cyc < 100) begin
            out_ready = tog ? (cyc % 3 == 0) : 1'b1;
            chk("drain_valid", out_valid, 1);
            if (!out_valid) break;
            if (stalled) begin
                chk("stall_data", out_data, pd);
                chk("stall_row", out_row, pr);
                chk("stall_col", out_col, pc);
                chk("stall_last", out_last, pl);
            end
            if (out_ready) begin
                chk("beat_data", out_data, ex[k]);
                chk("beat_row", out_row, k / 3);
                chk("beat_col", out_col, k % 3);
                chk("beat_last", out_last, k == n - 1);
                k++;
            end
            stalled = !out_ready;
            pd = out_data; pr = out_row; pc = out_col; pl = out_last;
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        chk("drain_beats", k, n);
        chk("after_valid", out_valid, 0);
        chk("after_count", collect_count, 0);
    endtask

    initial begin
        logic [15:0] ident [9];
        ident = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd1};
        // v0: comp_done in IDLE; v1..v9: writes; v10..v18: drain beats; v19: idle
        for (int v = 0; v < 20; v++) begin
            tv[v] = '{rv: 1'b0, din: 16'h0, done: 1'b0, rdy: 1'b1, ev: 1'b0, ed: 16'h0,
                      er: 2'd0, ec: 2'd0, el: 1'b0, ecnt: 4'd0};
            if (v == 0) tv[v].done = 1'b1;
            if (v >= 1 && v <= 9) begin
                tv[v].rv   = 1'b1;
                tv[v].din  = ident[v-1];
                tv[v].ecnt = 4'(v - 1);
            end
            if (v >= 10 && v <= 18) begin
                tv[v].ev   = 1'b1;
                tv[v].ed   = ident[v-10];
                tv[v].er   = 2'((v - 10) / 3);
                tv[v].ec   = 2'((v - 10) % 3);
                tv[v].el   = (v == 18);
                tv[v].ecnt = 4'd9;
                tv[v].done = (v == 12);
            end
        end

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_valid", out_valid, 0);
        chk("rst_full", buffer_full, 0);
        chk("rst_count", collect_count, 0);
        chk("rst_short", short_err, 0);
        chk("rst_ovf", overflow_err, 0);
        chk("rst_last", out_last, 0);

        // test 1: identity stream, always ready
        for (int v = 0; v < 20; v++) begin
            result_valid = tv[v].rv;
            result_in    = tv[v].din;
            comp_done    = tv[v].done;
            out_ready    = tv[v].rdy;
            chk("tv_valid", out_valid, tv[v].ev);
            chk("tv_full", buffer_full, tv[v].ev);
            chk("tv_count", collect_count, tv[v].ecnt);
            if (tv[v].ev) begin
                chk("tv_data", out_data, tv[v].ed);
                chk("tv_row", out_row, tv[v].er);
                chk("tv_col", out_col, tv[v].ec);
                chk("tv_last", out_last, tv[v].el);
            end
            tick();
        end
        result_valid = 1'b0; comp_done = 1'b0; out_ready = 1'b0;
        chk("t1_short", short_err, 0);

        // test 2: stalling consumer
        for (int i = 0; i < 9; i++) ex[i] = 16'h1100 + 16'(i * 17);
        feed(9);
        chk("t2_full", buffer_full, 1);
        drain(9, 1'b1);

        // test 3: short matrix via comp_done
        ex[0] = 16'd5; ex[1] = 16'd6; ex[2] = 16'd7; ex[3] = 16'd8;
        feed(4);
        chk("t3_not_full", buffer_full, 0);
        comp_done = 1'b1;
        tick();
        comp_done = 1'b0;
        chk("t3_short", short_err, 1);
        chk("t3_count", collect_count, 4);
        chk("t3_full", buffer_full, 1);
        drain(4, 1'b0);
        chk("t3_short_sticky", short_err, 1);

        // test 4: 9th result with comp_done, then overflow while draining
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t4_short_clr", short_err, 0);
        for (int i = 0; i < 9; i++) ex[i] = 16'h4000 + 16'(i);
        feed(8);
        result_valid = 1'b1; result_in = ex[8]; comp_done = 1'b1;
        tick();
        result_valid = 1'b0; comp_done = 1'b0;
        chk("t4_short", short_err, 0);
        chk("t4_full", buffer_full, 1);
        result_valid = 1'b1; result_in = 16'hBEEF;
        tick();
        result_valid = 1'b0;
        chk("t4_ovf", overflow_err, 1);
        chk("t4_count", collect_count, 9);
        drain(9, 1'b0);

        // test 5: clear mid-collect, with a result in the clear cycle
        for (int i = 0; i < 9; i++) ex[i] = 16'h5A00 + 16'(i * 3);
        feed(3);
        clear = 1'b1; result_valid = 1'b1; result_in = 16'hDEAD;
        tick();
        clear = 1'b0; result_valid = 1'b0;
        chk("t5_count", collect_count, 0);
        chk("t5_valid", out_valid, 0);
        chk("t5_ovf", overflow_err, 0);
        chk("t5_short", short_err, 0);
        tick();
        chk("t5_idle_count", collect_count, 0);
        feed(9);
        drain(9, 1'b0);

        // test 6: async reset in the middle of a drain
        for (int i = 0; i < 9; i++) ex[i] = 16'h6600 + 16'(i);
        feed(9);
        out_ready = 1'b1;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_full", buffer_full, 0);
        chk("t6_count", collect_count, 0);
        out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) ex[i] = 16'h7700 + 16'(i * 5);
        feed(9);
        drain(9, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
